// File: rtl/pwm_capture_if.sv
// ---------------------------------------------------------------------------
// pwm_capture_if
//   Signal bundle between a PWM source and the pwm_capture block.
//
//   pwm_in      1   external PWM line (asynchronous to the capture clock)
//   width_out  16   last accepted high time, in clk cycles
//   period_out 16   last accepted rise-to-rise period, in clk cycles
//   valid       1   single-cycle strobe, width_out/period_out updated
//   lost        1   signal-loss flag (level)
//
//   modport master : the side that drives pwm_in and observes the results
//   modport slave  : the capture block itself
// ---------------------------------------------------------------------------
interface pwm_capture_if;
    logic        pwm_in;
    logic [15:0] width_out;
    logic [15:0] period_out;
    logic        valid;
    logic        lost;

    modport master (
        output pwm_in,
        input  width_out,
        input  period_out,
        input  valid,
        input  lost
    );

    modport slave (
        input  pwm_in,
        output width_out,
        output period_out,
        output valid,
        output lost
    );
endinterface

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//   Measures high time and rise-to-rise period of an asynchronous PWM line.
//   A measurement is committed on the rising edge that closes a period if the
//   high time lies in [MIN_WIDTH, MAX_WIDTH] and no counter saturated.
//   TIMEOUT cycles without any edge declares signal loss and forces the
//   outputs to zero so a downstream motor drive stops.
//
//   Ports:
//     clk    system clock, rising-edge
//     rst_n  asynchronous active-low reset
//     bus    pwm_capture_if.slave (pwm_in in; width_out, period_out,
//            valid, lost out)
//
//   Optional build macro PWM_CAP_FILTER_EN: inserts a 3-sample glitch filter
//   behind the synchronizer (valid latency 5 clk instead of 3 clk).
// ---------------------------------------------------------------------------
module pwm_capture #(
    parameter int unsigned MIN_WIDTH = 256,
    parameter int unsigned MAX_WIDTH = 65280,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic         clk,
    input  logic         rst_n,
    pwm_capture_if.slave bus
);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;
    localparam logic [15:0] MIN_W     = 16'(MIN_WIDTH);
    localparam logic [15:0] MAX_W     = 16'(MAX_WIDTH);
    // Timeout fires on the clock where the idle count would reach TIMEOUT.
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    state_t      state_reg, state_next;
    logic        sync1_reg, sync2_reg, prev_reg;
    logic        level;
    logic        rise, fall, edge_det;
    logic [15:0] hi_cnt_reg, hi_cnt_next;
    logic [15:0] per_cnt_reg, per_cnt_next;
    logic [15:0] idle_cnt_reg, idle_cnt_next;
    logic [15:0] width_reg, width_next;
    logic [15:0] period_reg, period_next;
    logic        valid_reg, valid_next;
    logic        lost_reg, lost_next;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

`ifdef PWM_CAP_FILTER_EN
    // Two older synchronizer samples; the filtered level follows the input
    // only when the current and both older samples agree. prev_reg holds the
    // filtered level, so the edge is seen in the same cycle the filter flips.
    logic [1:0] hist_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_reg <= 2'b00;
        end else begin
            hist_reg <= {hist_reg[0], sync2_reg};
        end
    end

    assign level = ((sync2_reg == hist_reg[0]) && (hist_reg[0] == hist_reg[1]))
                   ? sync2_reg : prev_reg;
`else
    assign level = sync2_reg;
`endif

    assign rise     = level & ~prev_reg;
    assign fall     = ~level & prev_reg;
    assign edge_det = rise | fall;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= WAIT_RISE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, counters and output commit
    always_comb begin
        state_next    = state_reg;
        hi_cnt_next   = hi_cnt_reg;
        per_cnt_next  = per_cnt_reg;
        idle_cnt_next = edge_det ? 16'd0 : sat_inc(idle_cnt_reg);
        width_next    = width_reg;
        period_next   = period_reg;
        valid_next    = 1'b0;
        lost_next     = lost_reg;

        case (state_reg)
            WAIT_RISE: begin
                if (rise) begin
                    state_next   = MEAS_HIGH;
                    hi_cnt_next  = 16'd1;
                    per_cnt_next = 16'd1;
                end
            end
            MEAS_HIGH: begin
                per_cnt_next = sat_inc(per_cnt_reg);
                if (fall) begin
                    state_next = MEAS_LOW;     // hi_cnt frozen from here on
                end else begin
                    hi_cnt_next = sat_inc(hi_cnt_reg);
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    if ((hi_cnt_reg >= MIN_W) && (hi_cnt_reg <= MAX_W) &&
                        (hi_cnt_reg != CNT_MAX) && (per_cnt_reg != CNT_MAX)) begin
                        width_next  = hi_cnt_reg;
                        period_next = per_cnt_reg;
                        valid_next  = 1'b1;
                        lost_next   = 1'b0;
                    end
                    // This rise also opens the next period, so no gap.
                    state_next   = MEAS_HIGH;
                    hi_cnt_next  = 16'd1;
                    per_cnt_next = 16'd1;
                end else begin
                    per_cnt_next = sat_inc(per_cnt_reg);
                end
            end
            default: begin
                state_next = WAIT_RISE;
            end
        endcase

        // An edge in the timeout cycle keeps the signal alive. Without an
        // edge there is no valid this cycle, so valid and lost stay exclusive.
        if (!edge_det && (idle_cnt_reg == IDLE_LAST)) begin
            state_next    = WAIT_RISE;
            hi_cnt_next   = 16'd0;
            per_cnt_next  = 16'd0;
            idle_cnt_next = 16'd0;
            width_next    = 16'd0;
            period_next   = 16'd0;
            lost_next     = 1'b1;
        end
    end

    // Synchronizer, edge register, counters and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            prev_reg     <= 1'b0;
            hi_cnt_reg   <= 16'd0;
            per_cnt_reg  <= 16'd0;
            idle_cnt_reg <= 16'd0;
            width_reg    <= 16'd0;
            period_reg   <= 16'd0;
            valid_reg    <= 1'b0;
            lost_reg     <= 1'b1;
        end else begin
            sync1_reg    <= bus.pwm_in;
            sync2_reg    <= sync1_reg;
            prev_reg     <= level;
            hi_cnt_reg   <= hi_cnt_next;
            per_cnt_reg  <= per_cnt_next;
            idle_cnt_reg <= idle_cnt_next;
            width_reg    <= width_next;
            period_reg   <= period_next;
            valid_reg    <= valid_next;
            lost_reg     <= lost_next;
        end
    end

    assign bus.width_out  = width_reg;
    assign bus.period_out = period_reg;
    assign bus.valid      = valid_reg;
    assign bus.lost       = lost_reg;

endmodule
